// File: rtl/axi_burst_memory.sv
// AXI-style burst memory with independent write and read engines sharing one array.
// Write and read bursts support FIXED/INCR/WRAP addressing with per-beat range and protocol checks.
module axi_burst_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [31:0]             awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [31:0]             araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int AW    = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) * 33'(BYTES);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_t;

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [31:0] size;
        size = (32'(len) + 32'd1) << LSB;
        case (burst)
            2'd1:    next_addr = addr + 32'(BYTES);
            2'd2:    next_addr = (addr & ~(size - 32'd1)) | ((addr + 32'(BYTES)) & (size - 32'd1));
            default: next_addr = addr;
        endcase
    endfunction

    function automatic logic in_range(input logic [31:0] addr);
        return {1'b0, addr} < MEM_BYTES;
    endfunction

    function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'd3) ||
               ((burst == 2'd2) && !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
        return addr[LSB+AW-1:LSB];
    endfunction

    // Response codes are ordered so that the numerically larger one is the more severe.
    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t          w_state_r;
    logic [31:0]       w_addr_r;
    logic [7:0]        w_len_r;
    logic [1:0]        w_burst_r;
    logic [7:0]        w_cnt_r;
    logic [1:0]        w_err_r;
    logic [ID_WIDTH-1:0] bid_r;
    logic [1:0]        bresp_r;
    logic              bvalid_r;
    logic              w_last_s;
    logic              mem_we_s;
    logic [1:0]        w_beat_resp_s;

    r_state_t          r_state_r;
    logic [31:0]       r_addr_r;
    logic [7:0]        r_len_r;
    logic [1:0]        r_burst_r;
    logic [7:0]        r_cnt_r;
    logic [ID_WIDTH-1:0] rid_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]        rresp_r;
    logic              rlast_r;
    logic              rvalid_r;
    logic [1:0]        r_beat_resp_s;

    assign awready = (w_state_r == W_IDLE);
    assign wready  = (w_state_r == W_DATA);
    assign bid     = bid_r;
    assign bresp   = bresp_r;
    assign bvalid  = bvalid_r;
    assign arready = (r_state_r == R_IDLE);
    assign rid     = rid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
    assign rlast   = rlast_r;
    assign rvalid  = rvalid_r;

    // Per-beat write status and array write enable.
    always_comb begin
        w_last_s      = (w_cnt_r == w_len_r);
        w_beat_resp_s = OKAY;
        if (!in_range(w_addr_r)) begin
            w_beat_resp_s = DECERR;
        end else if (bad_burst(w_burst_r, w_len_r) || (wlast != w_last_s)) begin
            w_beat_resp_s = SLVERR;
        end else begin
            w_beat_resp_s = OKAY;
        end
        mem_we_s = (w_state_r == W_DATA) && wvalid && in_range(w_addr_r) &&
                   !bad_burst(w_burst_r, w_len_r);
    end

    // Write engine: address capture, data beats, response.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_r <= W_IDLE;
            w_addr_r  <= 32'd0;
            w_len_r   <= 8'd0;
            w_burst_r <= 2'd0;
            w_cnt_r   <= 8'd0;
            w_err_r   <= OKAY;
            bid_r     <= '0;
            bresp_r   <= OKAY;
            bvalid_r  <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: if (awvalid) begin
                    bid_r     <= awid;
                    w_addr_r  <= awaddr;
                    w_len_r   <= awlen;
                    w_burst_r <= awburst;
                    w_cnt_r   <= 8'd0;
                    w_err_r   <= OKAY;
                    w_state_r <= W_DATA;
                end
                W_DATA: if (wvalid) begin
                    w_addr_r <= next_addr(w_addr_r, w_len_r, w_burst_r);
                    w_cnt_r  <= w_cnt_r + 8'd1;
                    w_err_r  <= worse(w_err_r, w_beat_resp_s);
                    if (w_last_s) begin
                        bresp_r   <= worse(w_err_r, w_beat_resp_s);
                        bvalid_r  <= 1'b1;
                        w_state_r <= W_RESP;
                    end
                end
                W_RESP: if (bready) begin
                    bvalid_r  <= 1'b0;
                    bresp_r   <= OKAY;
                    w_state_r <= W_IDLE;
                end
                default: w_state_r <= W_IDLE;
            endcase
        end
    end

    // Array write port; contents survive reset.
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr_r)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Per-beat read status.
    always_comb begin
        r_beat_resp_s = OKAY;
        if (!in_range(r_addr_r)) begin
            r_beat_resp_s = DECERR;
        end else if (bad_burst(r_burst_r, r_len_r)) begin
            r_beat_resp_s = SLVERR;
        end else begin
            r_beat_resp_s = OKAY;
        end
    end

    // Read engine: one fetch cycle then a held data beat per transfer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_r <= R_IDLE;
            r_addr_r  <= 32'd0;
            r_len_r   <= 8'd0;
            r_burst_r <= 2'd0;
            r_cnt_r   <= 8'd0;
            rid_r     <= '0;
            rdata_r   <= '0;
            rresp_r   <= OKAY;
            rlast_r   <= 1'b0;
            rvalid_r  <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: if (arvalid) begin
                    rid_r     <= arid;
                    r_addr_r  <= araddr;
                    r_len_r   <= arlen;
                    r_burst_r <= arburst;
                    r_cnt_r   <= 8'd0;
                    r_state_r <= R_FETCH;
                end
                R_FETCH: begin
                    rdata_r   <= (r_beat_resp_s == OKAY) ? mem[word_idx(r_addr_r)] : '0;
                    rresp_r   <= r_beat_resp_s;
                    rlast_r   <= (r_cnt_r == r_len_r);
                    rvalid_r  <= 1'b1;
                    r_state_r <= R_DATA;
                end
                R_DATA: if (rready) begin
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                    r_addr_r  <= next_addr(r_addr_r, r_len_r, r_burst_r);
                    r_cnt_r   <= r_cnt_r + 8'd1;
                    r_state_r <= rlast_r ? R_IDLE : R_FETCH;
                end
                default: r_state_r <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_memory.sv
// Directed self-checking bench for axi_burst_memory (32-bit data, 1024 words, 4-bit IDs).
module tb_axi_burst_memory;
    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wd [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    int          wrap_ord [4] = '{2, 3, 0, 1};

    always #5 aclk = ~aclk;

    axi_burst_memory #(.DATA_WIDTH(32), .DEPTH(1024), .ID_WIDTH(4)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns on a falling edge; beats come from wd[].
    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] strb, input int bad_last,
                               input bit stall);
        int n;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge aclk); n++; end
        check("aw_ready", 32'(awready), 32'd1);
        @(negedge aclk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = strb;
            wlast = (i == int'(len)) ^ (i == bad_last);
            n = 0;
            while (!wready && n < 50) begin @(negedge aclk); n++; end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (n < 200) begin
            bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bvalid && bready) break;
            @(negedge aclk);
            n++;
        end
        check("b_valid", 32'(bvalid), 32'd1);
        check("bid", 32'(bid), 32'(id));
        b_resp = bresp; b_id = bid;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    // Called and returns on a falling edge; beats land in rd_data/rd_resp/rd_last.
    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input bit stall);
        int n, i;
        logic held;
        logic [31:0] hd;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge aclk); n++; end
        check("ar_ready", 32'(arready), 32'd1);
        @(negedge aclk);
        arvalid = 1'b0;
        i = 0; n = 0; held = 1'b0; hd = '0;
        while (i <= int'(len) && n < 300) begin
            rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rvalid) begin
                if (held) check("r_stable", rdata, hd);
                if (rready) begin
                    rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast;
                    check("rid", 32'(rid), 32'(id));
                    i++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = rdata;
                end
            end
            @(negedge aclk);
            n++;
        end
        rready = 1'b0;
        check("r_beats", 32'(i), 32'(len) + 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2 areset = 1'b1;
        repeat (2) @(negedge aclk);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_outs", {26'd0, wready, bvalid, rvalid, rlast, bresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // INCR write/read of 0x10..0x1C
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
        write_burst(4'h1, 32'h10, 8'd3, 2'd1, 4'hF, -1, 1'b0);
        check("incr_bresp", 32'(b_resp), 32'd0);
        read_burst(4'h2, 32'h10, 8'd3, 2'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("incr_rdata", rd_data[i], 32'hA0 + 32'(i));
            check("incr_rresp", 32'(rd_resp[i]), 32'd0);
            check("incr_rlast", 32'(rd_last[i]), (i == 3) ? 32'd1 : 32'd0);
        end

        // WRAP read starting mid-window
        read_burst(4'h3, 32'h18, 8'd3, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) check("wrap_rdata", rd_data[i], 32'hA0 + 32'(wrap_ord[i]));

        // Out-of-range write aliases word 0 if the range check is missing
        wd[0] = 32'h5A5A5A5A;
        write_burst(4'h0, 32'h0, 8'd0, 2'd1, 4'hF, -1, 1'b0);
        wd[0] = 32'hDEADBEEF;
        write_burst(4'h4, 32'h1000, 8'd0, 2'd1, 4'hF, -1, 1'b0);
        check("oor_bresp", 32'(b_resp), 32'd3);
        read_burst(4'h0, 32'h0, 8'd0, 2'd1, 1'b0);
        check("oor_nowrite", rd_data[0], 32'h5A5A5A5A);
        read_burst(4'h0, 32'h1000, 8'd0, 2'd1, 1'b0);
        check("oor_rresp", 32'(rd_resp[0]), 32'd3);
        check("oor_rdata", rd_data[0], 32'd0);

        // Byte strobes
        wd[0] = 32'hFFFFFFFF;
        write_burst(4'h0, 32'h20, 8'd0, 2'd1, 4'hF, -1, 1'b0);
        wd[0] = 32'h12345678;
        write_burst(4'h0, 32'h20, 8'd0, 2'd1, 4'b0101, -1, 1'b0);
        read_burst(4'h0, 32'h20, 8'd0, 2'd1, 1'b0);
        check("strb_rdata", rd_data[0], 32'hFF34FF78);

        // FIXED burst: last beat wins, reads repeat the same word
        wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
        write_burst(4'h6, 32'h40, 8'd2, 2'd0, 4'hF, -1, 1'b0);
        check("fixed_bresp", 32'(b_resp), 32'd0);
        read_burst(4'h6, 32'h40, 8'd1, 2'd0, 1'b0);
        check("fixed_rd0", rd_data[0], 32'h3);
        check("fixed_rd1", rd_data[1], 32'h3);

        // SLVERR cases: reserved burst, illegal WRAP length, early wlast
        wd[0] = 32'hCAFEF00D;
        write_burst(4'h0, 32'h30, 8'd0, 2'd1, 4'hF, -1, 1'b0);
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333;
        write_burst(4'h7, 32'h30, 8'd0, 2'd3, 4'hF, -1, 1'b0);
        check("rsv_bresp", 32'(b_resp), 32'd2);
        write_burst(4'h7, 32'h30, 8'd2, 2'd2, 4'hF, -1, 1'b0);
        check("wrap_len_bresp", 32'(b_resp), 32'd2);
        read_burst(4'h0, 32'h30, 8'd0, 2'd1, 1'b0);
        check("slv_nowrite", rd_data[0], 32'hCAFEF00D);
        read_burst(4'h8, 32'h30, 8'd0, 2'd3, 1'b0);
        check("rsv_rresp", 32'(rd_resp[0]), 32'd2);
        check("rsv_rdata", rd_data[0], 32'd0);
        wd[0] = 32'h77; wd[1] = 32'h88;
        write_burst(4'h9, 32'h34, 8'd1, 2'd1, 4'hF, 0, 1'b0);
        check("wlast_bresp", 32'(b_resp), 32'd2);
        read_burst(4'h0, 32'h34, 8'd1, 2'd1, 1'b0);
        check("wlast_rd0", rd_data[0], 32'h77);
        check("wlast_rd1", rd_data[1], 32'h88);

        // DECERR outranks SLVERR; burst crosses the top of memory
        wd[0] = 32'h0BADF00D; wd[1] = 32'h99;
        write_burst(4'hA, 32'hFFC, 8'd1, 2'd1, 4'hF, 0, 1'b0);
        check("prio_bresp", 32'(b_resp), 32'd3);
        read_burst(4'hA, 32'hFFC, 8'd1, 2'd1, 1'b0);
        check("edge_rd0", rd_data[0], 32'h0BADF00D);
        check("edge_rresp0", 32'(rd_resp[0]), 32'd0);
        check("edge_rresp1", 32'(rd_resp[1]), 32'd3);
        check("edge_rd1", rd_data[1], 32'd0);
        check("edge_rlast", 32'(rd_last[1]), 32'd1);

        // Concurrent bursts with random backpressure
        for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + 32'(i);
        fork
            write_burst(4'h5, 32'h50, 8'd3, 2'd1, 4'hF, -1, 1'b1);
            read_burst(4'h9, 32'h10, 8'd3, 2'd1, 1'b1);
        join
        check("conc_bresp", 32'(b_resp), 32'd0);
        check("conc_bid", 32'(b_id), 32'h5);
        for (int i = 0; i < 4; i++) check("conc_rdata", rd_data[i], 32'hA0 + 32'(i));
        read_burst(4'h1, 32'h50, 8'd3, 2'd1, 1'b1);
        for (int i = 0; i < 4; i++) check("conc_wdata", rd_data[i], 32'hB0 + 32'(i));

        // Reset in the middle of a stalled read and a half-done write
        araddr = 32'h10; arid = 4'h3; arlen = 8'd3; arburst = 2'd1; arvalid = 1'b1; rready = 1'b0;
        @(negedge aclk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 10) begin @(negedge aclk); n++; end
        awaddr = 32'h60; awid = 4'h2; awlen = 8'd3; awburst = 2'd1; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF; wlast = 1'b0;
        repeat (2) @(negedge aclk);
        check("pre_rst_rvalid", 32'(rvalid), 32'd1);
        check("pre_rst_wready", 32'(wready), 32'd1);
        #2 areset = 1'b1;
        #1;
        check("mid_rst_ready", {30'd0, awready, arready}, 32'd3);
        check("mid_rst_outs", {24'd0, wready, bvalid, rvalid, rlast, rresp, bresp}, 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_ids", {24'd0, bid, rid}, 32'd0);
        wvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        read_burst(4'h4, 32'h10, 8'd0, 2'd1, 1'b0);
        check("post_rst_rdata", rd_data[0], 32'hA0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_burst_memory.md
AXI_BURST_MEMORY -- requirements
Module: axi_burst_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits (multiple of 8, power of 2).
REQ-002 SHALL have parameter DEPTH, default 1024, number of DATA_WIDTH words in the internal array.
REQ-003 SHALL have parameter ID_WIDTH, default 4, width of the AXI ID fields.
REQ-004 SHALL have port aclk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port awid  input  ID_WIDTH  write burst ID.
REQ-007 SHALL have port awaddr  input  32  write start byte address.
REQ-008 SHALL have port awlen  input  8  write beats minus one.
REQ-009 SHALL have port awburst  input  2  write burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-010 SHALL have port awvalid  input  1  write address valid.
REQ-011 SHALL have port awready  output  1  write address ready.
REQ-012 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-013 SHALL have port wstrb  input  DATA_WIDTH/8  byte write enables.
REQ-014 SHALL have port wlast  input  1  last write beat marker.
REQ-015 SHALL have port wvalid  input  1  write data valid.
REQ-016 SHALL have port wready  output  1  write data ready.
REQ-017 SHALL have port bid  output  ID_WIDTH  response ID, equal to the latched awid.
REQ-018 SHALL have port bresp  output  2  write response.
REQ-019 SHALL have port bvalid  output  1  write response valid.
REQ-020 SHALL have port bready  input  1  write response ready.
REQ-021 SHALL have port arid  input  ID_WIDTH  read burst ID.
REQ-022 SHALL have port araddr  input  32  read start byte address.
REQ-023 SHALL have port arlen  input  8  read beats minus one.
REQ-024 SHALL have port arburst  input  2  read burst type, encoded as awburst.
REQ-025 SHALL have port arvalid  input  1  read address valid.
REQ-026 SHALL have port arready  output  1  read address ready.
REQ-027 SHALL have port rid  output  ID_WIDTH  read ID, equal to the latched arid.
REQ-028 SHALL have port rdata  output  DATA_WIDTH  read data, held stable while rvalid=1 and rready=0.
REQ-029 SHALL have port rresp  output  2  per-beat read response.
REQ-030 SHALL have port rlast  output  1  last read beat marker.
REQ-031 SHALL have port rvalid  output  1  read data valid.
REQ-032 SHALL have port rready  input  1  read data ready.

Function
REQ-033 SHALL run independent write and read engines concurrently over one internal array with 1 write port and 1 read port; transfers are full-width only, LSB = log2(DATA_WIDTH/8), word index = addr[LSB+log2(DEPTH)-1:LSB].
REQ-034 Write FSM SHALL have states W_IDLE -> W_DATA -> W_RESP -> W_IDLE; awready=1 only in W_IDLE; AW handshake latches id/addr/len/burst; wready=1 only in W_DATA.
REQ-035 Each W handshake SHALL write the bytes enabled by wstrb at the current beat address in the same cycle; after beat awlen+1 the FSM SHALL enter W_RESP regardless of wlast, and bvalid SHALL hold until bready, after which it returns to W_IDLE.
REQ-036 Read FSM SHALL have states R_IDLE -> R_FETCH -> R_DATA; arready=1 only in R_IDLE; R_FETCH issues the array read (1-cycle latency) and registers rdata; R_DATA holds rvalid=1 until rready; on handshake go to R_FETCH for the next beat, or to R_IDLE after beat arlen+1; rlast=1 on the final beat only.
REQ-037 Beat address SHALL follow: FIXED unchanged; INCR +DATA_WIDTH/8 per beat; WRAP +DATA_WIDTH/8 per beat, wrapping within the aligned (len+1)*DATA_WIDTH/8 byte window.
REQ-038 Out-of-range beat (byte address >= DEPTH*DATA_WIDTH/8) SHALL return DECERR (2'b11): a write beat SHALL not be written, and a read beat SHALL return rdata=0; the address SHALL keep advancing.
REQ-039 SLVERR (2'b10) SHALL be reported for the reserved burst type, for WRAP with len not in {1,3,7,15}, or for a wlast mismatch on any beat; with reserved or illegal WRAP, no array writes SHALL occur and read data SHALL be 0.
REQ-040 bresp SHALL be the highest-priority error across all beats (DECERR > SLVERR > OKAY); rresp SHALL be evaluated per beat.
REQ-041 A read and a write to the same word in the same cycle SHALL return the old data (read-first).
REQ-042 Throughput SHALL be 1 write beat per cycle and 1 read beat per 2 cycles.

Reset
REQ-043 areset=1 SHALL asynchronously force W_IDLE and R_IDLE, drive awready=1, arready=1 and all other outputs to 0, and abort any burst in flight; array contents SHALL not be cleared.

Verification
REQ-044 INCR write, awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF -> bresp=OKAY; INCR read of the same burst -> 0xA0..0xA3 with rlast on beat 4.
REQ-045 WRAP read, araddr=0x18, arlen=3 -> words read from byte addresses 0x18, 0x1C, 0x10, 0x14.
REQ-046 Write to 0x1000 (DEPTH=1024, 32-bit) -> bresp=2'b11 and no array change; read of 0x1000 -> rresp=2'b11, rdata=0.
REQ-047 Concurrent 4-beat write and 4-beat read with random rready/bready stalls -> both bursts complete, rdata is stable during stalls, and bid/rid match the request IDs.
REQ-048 wstrb=4'b0101 over 0xFFFFFFFF with wdata=0x12345678 -> readback 0xFF34FF78; areset asserted mid-burst -> all outputs at reset values within the same cycle.
